// File: rtl/sdram.sv
// sdram: behavioural SDRAM endpoint, 16 rows x 16 columns x 8 bits.
// Every access is a fixed 4-beat burst with CAS latency 2, and the column
// wraps inside the active row. Commands are only decoded while idle.
module sdram (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] partial_address_bus,
    input  logic       chip_enable_not,
    input  logic       write_not,
    input  logic       ras_not,
    input  logic       cas_not,
    inout  wire  [7:0] data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] row_q,   row_d;
    logic [3:0] col_q,   col_d;
    logic [1:0] beat_q,  beat_d;
    logic       rd_q,    rd_d;      // 1 = read burst, 0 = write burst

    logic [7:0] mem_q [0:255];

    logic       row_cmd;
    logic       col_cmd;
    logic [3:0] beat_col;
    logic [7:0] beat_addr;
    logic       wr_en;
    logic       rd_en;

    assign row_cmd = !chip_enable_not && !ras_not &&  cas_not;
    assign col_cmd = !chip_enable_not &&  ras_not && !cas_not;

    // Column advances per beat and wraps modulo 16 within the row.
    assign beat_col  = col_q + {2'b00, beat_q};
    assign beat_addr = {row_q, beat_col};

    assign wr_en = (state_q == ST_BURST) && !rd_q;
    assign rd_en = (state_q == ST_BURST) &&  rd_q;

    // Read beat k is presented for the whole cycle ending at its sampling edge.
    assign data = rd_en ? mem_q[beat_addr] : 8'bz;

    // Control state; reset drops any burst in flight and releases the bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            beat_q  <= 2'd0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            beat_q  <= beat_d;
            rd_q    <= rd_d;
        end
    end

    // Command decode while idle, latency cycle, then four burst beats.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        beat_d  = beat_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (row_cmd) begin
                    row_d = partial_address_bus;
                end else if (col_cmd) begin
                    col_d   = partial_address_bus;
                    rd_d    = write_not;
                    state_d = ST_LAT;
                end
            end
            ST_LAT: begin
                beat_d  = 2'd0;
                state_d = ST_BURST;
            end
            ST_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage array: not reset, so contents survive a reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[beat_addr] <= data;
        end
    end

endmodule

// File: tb/tb_sdram.sv
// tb_sdram: directed bench for the sdram endpoint with a cycle-scheduled
// reference model and literal burst expectations.
module tb_sdram;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] addr;
    logic       ce_n, we_n, ras_n, cas_n;
    wire  [7:0] data;
    logic       tb_oe;
    logic [7:0] tb_wd;

    int tests = 0;
    int fails = 0;

    assign data = tb_oe ? tb_wd : 8'hzz;
    pullup (data);

    always #5 clock = ~clock;

    sdram dut (
        .clock               (clock),
        .reset               (reset),
        .partial_address_bus (addr),
        .chip_enable_not     (ce_n),
        .write_not           (we_n),
        .ras_not             (ras_n),
        .cas_not             (cas_n),
        .data                (data)
    );

    // Reference model: a command at edge C schedules beat k at edge C+2+k,
    // and the device is busy until edge C+6.
    logic [7:0] mem_m   [256];
    bit         known_m [256];
    logic [3:0] row_m   = 4'd0;
    int         cyc     = 0;
    int         next_ok = 0;
    bit         s_rd [8];
    bit         s_wr [8];
    logic [7:0] s_a  [8];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            row_m   = 4'd0;
            next_ok = 0;
            for (int i = 0; i < 8; i++) begin
                s_rd[i] = 1'b0;
                s_wr[i] = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            if (s_wr[cyc % 8]) begin
                mem_m[s_a[cyc % 8]]   = data;
                known_m[s_a[cyc % 8]] = 1'b1;
            end
            s_wr[cyc % 8] = 1'b0;
            s_rd[cyc % 8] = 1'b0;
            if (cyc >= next_ok && !ce_n) begin
                if (!ras_n && cas_n) begin
                    row_m = addr;
                end else if (ras_n && !cas_n) begin
                    for (int k = 0; k < 4; k++) begin
                        s_a[(cyc + 2 + k) % 8] = {row_m, 4'(addr + k)};
                        if (we_n) s_rd[(cyc + 2 + k) % 8] = 1'b1;
                        else      s_wr[(cyc + 2 + k) % 8] = 1'b1;
                    end
                    next_ok = cyc + 6;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Bus check every cycle the bench is not driving: either the scheduled
    // read beat for the next edge, or the idle pulled-up value.
    always @(negedge clock) begin : cmp
        int i;
        i = (cyc + 1) % 8;
        if (!tb_oe) begin
            if (!reset && s_rd[i]) begin
                if (known_m[s_a[i]]) check("bus_read", {24'd0, data}, {24'd0, mem_m[s_a[i]]});
            end else begin
                check("bus_idle", {24'd0, data}, 32'h0000_00FF);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        ce_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; addr = 4'd0;
    endtask

    task automatic cmd_row(input logic [3:0] r);
        ce_n = 1'b0; ras_n = 1'b0; cas_n = 1'b1; addr = r;
        step();
        nop();
    endtask

    task automatic cmd_col(input logic [3:0] c, input logic wn);
        ce_n = 1'b0; ras_n = 1'b1; cas_n = 1'b0; we_n = wn; addr = c;
        step();
        nop();
    endtask

    task automatic write_burst(input logic [3:0] c, input logic [31:0] d);
        cmd_col(c, 1'b0);
        step();
        tb_oe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tb_wd = d[31 - 8*k -: 8];
            step();
        end
        tb_oe = 1'b0;
    endtask

    task automatic read_burst(input logic [3:0] c, output logic [31:0] got);
        cmd_col(c, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            got[31 - 8*k -: 8] = data;
        end
        step();
    endtask

    logic [31:0] got;

    initial begin
        reset = 1'b1;
        tb_oe = 1'b0;
        tb_wd = 8'h00;
        nop();
        #1;
        check("reset_hiz", {24'd0, data}, 32'h0000_00FF);
        step();
        step();
        reset = 1'b0;
        step();

        // Seed row 0 so the post-reset row register can be observed later.
        cmd_row(4'd0);
        write_burst(4'd4, 32'hA1A2_A3A4);

        // Basic write/read.
        cmd_row(4'd3);
        write_burst(4'd2, 32'hAABB_CCDD);
        cmd_row(4'd3);
        read_burst(4'd2, got);
        check("basic_read", got, 32'hAABB_CCDD);

        // Column wrap within row 5.
        cmd_row(4'd5);
        write_burst(4'd0, 32'h1020_3040);
        write_burst(4'd14, 32'h1122_3344);
        read_burst(4'd0, got);
        check("wrap_read_col0", got, 32'h3344_3040);
        read_burst(4'd14, got);
        check("wrap_read_col14", got, 32'h1122_3344);

        // Row isolation.
        cmd_row(4'd1);
        write_burst(4'd0, 32'h0102_0304);
        cmd_row(4'd2);
        write_burst(4'd0, 32'hF1F2_F3F4);
        cmd_row(4'd1);
        read_burst(4'd0, got);
        check("row_isolation", got, 32'h0102_0304);

        // Deselected read command: no bus drive.
        ce_n = 1'b1; ras_n = 1'b1; cas_n = 1'b0; we_n = 1'b1; addr = 4'd0;
        step();
        nop();
        for (int k = 0; k < 6; k++) step();
        // Deselected write and ras=cas=0 write while the bench drives EE.
        ce_n = 1'b1; ras_n = 1'b1; cas_n = 1'b0; we_n = 1'b0; addr = 4'd0;
        step();
        nop();
        tb_oe = 1'b1; tb_wd = 8'hEE;
        for (int k = 0; k < 6; k++) step();
        tb_oe = 1'b0;
        ce_n = 1'b0; ras_n = 1'b0; cas_n = 1'b0; we_n = 1'b0; addr = 4'd0;
        step();
        nop();
        tb_oe = 1'b1; tb_wd = 8'hEE;
        for (int k = 0; k < 6; k++) step();
        tb_oe = 1'b0;
        for (int k = 0; k < 2; k++) step();
        cmd_row(4'd1);
        read_burst(4'd0, got);
        check("nop_mem_unchanged", got, 32'h0102_0304);

        // Row activate during a read burst is ignored.
        cmd_row(4'd3);
        cmd_col(4'd2, 1'b1);
        step();
        got[31:24] = data;
        step();
        got[23:16] = data;
        ce_n = 1'b0; ras_n = 1'b0; cas_n = 1'b1; addr = 4'd9;
        step();
        nop();
        got[15:8] = data;
        step();
        got[7:0] = data;
        step();
        check("cmd_in_burst_read", got, 32'hAABB_CCDD);
        read_burst(4'd2, got);
        check("row_kept_after_burst", got, 32'hAABB_CCDD);

        // Reset in the middle of a read releases the bus at once.
        cmd_col(4'd2, 1'b1);
        step();
        step();
        reset = 1'b1;
        #1;
        check("reset_read_hiz", {24'd0, data}, 32'h0000_00FF);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Reset in the middle of a write keeps only beats 0 and 1.
        cmd_row(4'd4);
        write_burst(4'd4, 32'h0102_0304);
        cmd_col(4'd4, 1'b0);
        step();
        tb_oe = 1'b1;
        tb_wd = 8'h5A;
        step();
        tb_wd = 8'h5B;
        step();
        tb_oe = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_write_hiz", {24'd0, data}, 32'h0000_00FF);
        step();
        reset = 1'b0;
        step();
        read_burst(4'd4, got);
        check("row0_after_reset", got, 32'hA1A2_A3A4);
        cmd_row(4'd4);
        read_burst(4'd4, got);
        check("partial_write", got, 32'h5A5B_0304);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
